// File: rtl/rf_cmd_ctrl.sv
// rf_cmd_ctrl: decodes UART command frames into register file write/read strobes and returns
// read data as a byte over a valid/busy handshake. Define RF_CMD_CTRL_TIMEOUT_EN for the read timeout and o_Err.
//
// state    | meaning
// IDLE     | waiting for a WR_CMD or RD_CMD opcode byte
// WR_ADDR  | waiting for the write address byte
// WR_DATA  | waiting for the write data byte
// WR_EXEC  | write strobe high for one cycle
// RD_ADDR  | waiting for the read address byte
// RD_EXEC  | read strobe high for one cycle
// RD_WAIT  | waiting for read data valid (or timeout)
// TX_SEND  | presenting the read byte until the transmitter accepts it
module rf_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD = 8'hBB,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [DATA_WIDTH-1:0] i_RX_Data,
  input  logic                  i_RX_Valid,
  output logic                  o_RF_WrEn,
  output logic                  o_RF_RdEn,
  output logic [ADDR_WIDTH-1:0] o_RF_Address,
  output logic [DATA_WIDTH-1:0] o_RF_WrData,
  input  logic [DATA_WIDTH-1:0] i_RF_RdData,
  input  logic                  i_RF_RdData_Valid,
  output logic [DATA_WIDTH-1:0] o_TX_Data,
  output logic                  o_TX_Valid,
  input  logic                  i_TX_Busy,
  output logic                  o_Busy
`ifdef RF_CMD_CTRL_TIMEOUT_EN
  ,
  output logic                  o_Err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_EXEC,
    S_RD_ADDR,
    S_RD_EXEC,
    S_RD_WAIT,
    S_TX_SEND
  } state_t;

  state_t state;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rf_cmd_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef RF_CMD_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // o_Busy is registered alongside the state so it tracks the state it describes.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state        <= S_IDLE;
      o_RF_WrEn    <= 1'b0;
      o_RF_RdEn    <= 1'b0;
      o_RF_Address <= '0;
      o_RF_WrData  <= '0;
      o_TX_Data    <= '0;
      o_TX_Valid   <= 1'b0;
      o_Busy       <= 1'b0;
`ifdef RF_CMD_CTRL_TIMEOUT_EN
      o_Err        <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (i_RX_Valid) begin
            if (i_RX_Data == WR_CMD) begin
              state <= S_WR_ADDR;
`ifdef RF_CMD_CTRL_TIMEOUT_EN
              o_Err <= 1'b0;
`endif
            end else if (i_RX_Data == RD_CMD) begin
              state <= S_RD_ADDR;
`ifdef RF_CMD_CTRL_TIMEOUT_EN
              o_Err <= 1'b0;
`endif
            end
          end
        end
        S_WR_ADDR: begin
          if (i_RX_Valid) begin
            o_RF_Address <= i_RX_Data[ADDR_WIDTH-1:0];
            state        <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (i_RX_Valid) begin
            o_RF_WrData <= i_RX_Data;
            o_RF_WrEn   <= 1'b1;
            o_Busy      <= 1'b1;
            state       <= S_WR_EXEC;
          end
        end
        S_WR_EXEC: begin
          o_RF_WrEn <= 1'b0;
          o_Busy    <= 1'b0;
          state     <= S_IDLE;
        end
        S_RD_ADDR: begin
          if (i_RX_Valid) begin
            o_RF_Address <= i_RX_Data[ADDR_WIDTH-1:0];
            o_RF_RdEn    <= 1'b1;
            o_Busy       <= 1'b1;
            state        <= S_RD_EXEC;
          end
        end
        S_RD_EXEC: begin
          o_RF_RdEn <= 1'b0;
          state     <= S_RD_WAIT;
`ifdef RF_CMD_CTRL_TIMEOUT_EN
          tmo_cnt   <= TMO_LOAD;
`endif
        end
        S_RD_WAIT: begin
          if (i_RF_RdData_Valid) begin
            o_TX_Data  <= i_RF_RdData;
            o_TX_Valid <= 1'b1;
            state      <= S_TX_SEND;
          end
`ifdef RF_CMD_CTRL_TIMEOUT_EN
          // Terminal count reached on the TIMEOUT_CYCLES-th cycle spent here.
          else if (tmo_cnt == '0) begin
            o_TX_Data  <= '1;
            o_TX_Valid <= 1'b1;
            o_Err      <= 1'b1;
            state      <= S_TX_SEND;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
`endif
        end
        S_TX_SEND: begin
          if (!i_TX_Busy) begin
            o_TX_Valid <= 1'b0;
            o_Busy     <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          o_RF_WrEn  <= 1'b0;
          o_RF_RdEn  <= 1'b0;
          o_TX_Valid <= 1'b0;
          o_Busy     <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// tb_rf_cmd_ctrl: frame-level reference model with queued expectations, directed cases with literal
// values, then randomized frames, junk bytes, read latency and transmitter backpressure.
module tb_rf_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_en, rd_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic       busy;
`ifdef RF_CMD_CTRL_TIMEOUT_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  rf_cmd_ctrl dut (
    .i_CLK(clk),
    .i_RST(rst_n),
    .i_RX_Data(rx_data),
    .i_RX_Valid(rx_valid),
    .o_RF_WrEn(wr_en),
    .o_RF_RdEn(rd_en),
    .o_RF_Address(rf_addr),
    .o_RF_WrData(rf_wdata),
    .i_RF_RdData(rd_data),
    .i_RF_RdData_Valid(rd_valid),
    .o_TX_Data(tx_data),
    .o_TX_Valid(tx_valid),
    .i_TX_Busy(tx_busy),
    .o_Busy(busy)
`ifdef RF_CMD_CTRL_TIMEOUT_EN
    ,
    .o_Err(err)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [3:0] exp_rd[$];
  logic [7:0] exp_tx[$];
  logic [7:0] model_mem[16];
  logic [7:0] env_mem[16];

  int n_checks = 0;
  int n_fail   = 0;
  int wr_seen  = 0;
  int rd_seen  = 0;
  int tx_seen  = 0;
  int lat      = 1;
  bit resp_en  = 1'b1;
  bit rand_busy = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison of DUT outputs against the queued frame-level expectations.
  logic       prev_wr, prev_rd, prev_hold, prev_hs;
  logic [7:0] prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 0; prev_rd = 0; prev_hold = 0; prev_hs = 0; prev_data = 0;
    end else begin
      if (wr_en || rd_en) begin
        check_eq("strobe_exclusive", {31'd0, wr_en & rd_en}, 0);
        check_eq("busy_in_strobe", {31'd0, busy}, 1);
      end
      if (wr_en) begin
        check_eq("wr_one_cycle", {31'd0, prev_wr}, 0);
        if (exp_wr.size() == 0) fail_now("unexpected_wr", 1, 0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check_eq("wr_addr", {28'd0, rf_addr}, {28'd0, w.a});
          check_eq("wr_data", {24'd0, rf_wdata}, {24'd0, w.d});
        end
        wr_seen++;
      end
      if (rd_en) begin
        check_eq("rd_one_cycle", {31'd0, prev_rd}, 0);
        if (exp_rd.size() == 0) fail_now("unexpected_rd", 1, 0);
        else check_eq("rd_addr", {28'd0, rf_addr}, {28'd0, exp_rd.pop_front()});
        rd_seen++;
      end
      if (prev_hold) begin
        check_eq("tx_valid_held", {31'd0, tx_valid}, 1);
        check_eq("tx_data_held", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (prev_hs) check_eq("tx_valid_drop", {31'd0, tx_valid}, 0);
      if (tx_valid) check_eq("busy_in_tx", {31'd0, busy}, 1);
      if (tx_valid && !tx_busy) begin
        if (exp_tx.size() == 0) fail_now("unexpected_tx", 1, 0);
        else check_eq("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        tx_seen++;
      end
      prev_wr   = wr_en;
      prev_rd   = rd_en;
      prev_hold = tx_valid & tx_busy;
      prev_hs   = tx_valid & ~tx_busy;
      prev_data = tx_data;
    end
  end

  // Register file responder and its own memory, updated only from observed DUT writes.
  initial begin
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && wr_en) env_mem[rf_addr] = rf_wdata;
      if (rst_n && rd_en && resp_en) begin
        logic [3:0] a;
        a = rf_addr;
        repeat (lat) @(posedge clk);
        #1;
        rd_valid = 1'b1;
        rd_data  = env_mem[a];
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rd_data  = $urandom_range(0, 255);
      end
    end
  end

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_busy) tx_busy = ($urandom_range(0, 9) < 3);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_wr(input int target);
    int k = 0;
    while (wr_seen < target && k < 50) begin @(negedge clk); #1; k++; end
    if (wr_seen < target) fail_now("wr_wait_timeout", wr_seen, target);
  endtask

  task automatic wait_tx(input int target);
    int k = 0;
    while (tx_seen < target && k < 300) begin @(negedge clk); #1; k++; end
    if (tx_seen < target) fail_now("tx_wait_timeout", tx_seen, target);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    int target;
    w.a = a[3:0];
    w.d = d;
    exp_wr.push_back(w);
    model_mem[a[3:0]] = d;
    target = wr_seen + 1;
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    wait_wr(target);
  endtask

  task automatic do_read(input logic [7:0] a, input bit junk_en, input logic [7:0] junk);
    int target;
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(model_mem[a[3:0]]);
    target = tx_seen + 1;
    send_byte(8'hBB);
    send_byte(a);
    if (junk_en) begin
      @(negedge clk);
      rx_data  = junk;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
    wait_tx(target);
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_wr"}, {31'd0, wr_en}, 0);
    check_eq({name, "_rd"}, {31'd0, rd_en}, 0);
    check_eq({name, "_addr"}, {28'd0, rf_addr}, 0);
    check_eq({name, "_wdata"}, {24'd0, rf_wdata}, 0);
    check_eq({name, "_txd"}, {24'd0, tx_data}, 0);
    check_eq({name, "_txv"}, {31'd0, tx_valid}, 0);
    check_eq({name, "_busy"}, {31'd0, busy}, 0);
`ifdef RF_CMD_CTRL_TIMEOUT_EN
    check_eq({name, "_err"}, {31'd0, err}, 0);
`endif
  endtask

  initial begin
    int k;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      v = $urandom_range(0, 255);
      model_mem[i] = v;
      env_mem[i]   = v;
    end
    model_mem[10] = 8'hC8;
    env_mem[10]   = 8'hC8;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write frame AA 07 64: strobe on the cycle after the data byte.
    exp_wr.push_back('{a: 4'd7, d: 8'd100});
    model_mem[7] = 8'd100;
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h64);
    check_eq("dir_wr_pulse", {31'd0, wr_en}, 1);
    check_eq("dir_wr_addr", {28'd0, rf_addr}, 7);
    check_eq("dir_wr_data", {24'd0, rf_wdata}, 100);
    check_eq("dir_wr_txv", {31'd0, tx_valid}, 0);
    @(negedge clk);
    check_eq("dir_wr_end", {31'd0, wr_en}, 0);
    check_eq("dir_wr_idle", {31'd0, busy}, 0);

    // Read frame BB 0A, data valid one cycle after RdEn.
    lat = 1;
    exp_rd.push_back(4'd10);
    exp_tx.push_back(8'hC8);
    send_byte(8'hBB);
    send_byte(8'h0A);
    check_eq("dir_rd_pulse", {31'd0, rd_en}, 1);
    check_eq("dir_rd_addr", {28'd0, rf_addr}, 10);
    @(negedge clk);
    check_eq("dir_rd_wait_txv", {31'd0, tx_valid}, 0);
    check_eq("dir_rd_wait_busy", {31'd0, busy}, 1);
    @(negedge clk);
    check_eq("dir_rd_txv", {31'd0, tx_valid}, 1);
    check_eq("dir_rd_txd", {24'd0, tx_data}, 8'hC8);
    @(negedge clk);
    check_eq("dir_rd_done_txv", {31'd0, tx_valid}, 0);
    check_eq("dir_rd_done_busy", {31'd0, busy}, 0);

    // Same read under five cycles of transmitter backpressure.
    @(posedge clk); #1 tx_busy = 1'b1;
    exp_rd.push_back(4'd10);
    exp_tx.push_back(8'hC8);
    send_byte(8'hBB);
    send_byte(8'h0A);
    k = 0;
    while (!tx_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_txv", {31'd0, tx_valid}, 1);
      check_eq("bp_txd", {24'd0, tx_data}, 8'hC8);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 tx_busy = 1'b0;
    @(negedge clk);
    check_eq("bp_release_txv", {31'd0, tx_valid}, 1);
    @(negedge clk);
    check_eq("bp_after_txv", {31'd0, tx_valid}, 0);
    check_eq("bp_after_busy", {31'd0, busy}, 0);
    check_eq("bp_single_tx", tx_seen, 2);

    // Bad opcode in IDLE, then a junk byte dropped during RD_WAIT.
    send_byte(8'h55);
    repeat (4) @(negedge clk);
    check_eq("bad_op_busy", {31'd0, busy}, 0);
    check_eq("bad_op_no_wr", wr_seen, 1);
    lat = 3;
    do_read(8'h0A, 1'b1, 8'h11);
    check_eq("junk_rd_txd", {24'd0, tx_data}, 8'hC8);

    // Reset in the middle of a write frame.
    send_byte(8'hAA);
    send_byte(8'h03);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h99);
    repeat (5) @(negedge clk);
    check_eq("mid_reset_no_wr", wr_seen, 1);
    do_write(8'h03, 8'h22);
    check_eq("post_reset_addr", {28'd0, rf_addr}, 3);
    check_eq("post_reset_data", {24'd0, rf_wdata}, 8'h22);

`ifdef RF_CMD_CTRL_TIMEOUT_EN
    // Read with no response: 16 cycles in RD_WAIT, then 8'hFF with o_Err.
    resp_en = 1'b0;
    exp_rd.push_back(4'd5);
    exp_tx.push_back(8'hFF);
    send_byte(8'hBB);
    send_byte(8'h05);
    check_eq("tmo_rd_pulse", {31'd0, rd_en}, 1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq("tmo_wait_txv", {31'd0, tx_valid}, 0);
    end
    @(negedge clk);
    check_eq("tmo_txv", {31'd0, tx_valid}, 1);
    check_eq("tmo_txd", {24'd0, tx_data}, 8'hFF);
    check_eq("tmo_err", {31'd0, err}, 1);
    repeat (2) @(negedge clk);
    check_eq("tmo_err_sticky", {31'd0, err}, 1);
    resp_en = 1'b1;
    exp_wr.push_back('{a: 4'd5, d: 8'h12});
    model_mem[5] = 8'h12;
    send_byte(8'hAA);
    check_eq("tmo_err_cleared", {31'd0, err}, 0);
    send_byte(8'h05);
    send_byte(8'h12);
    wait_wr(wr_seen + 1);
`endif

    // Randomized frames, junk bytes, read latency and backpressure.
    rand_busy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end else if (op < 8) begin
        lat = $urandom_range(1, 6);
        do_read(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end else begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA || b == 8'hBB) b = b ^ 8'h01;
        send_byte(b);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_busy = 1'b0;
    @(posedge clk); #1 tx_busy = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("left_exp_wr", exp_wr.size(), 0);
    check_eq("left_exp_rd", exp_rd.size(), 0);
    check_eq("left_exp_tx", exp_tx.size(), 0);
    check_eq("final_idle", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_cmd_ctrl.md
Name: rf_cmd_ctrl

Overview:
Command controller that acts as the initiator side of the register file access interface. It collects command bytes from the UART receive path and decodes write and read frames. It drives the register file write/read strobes, address and write data. For reads, it captures the read data once valid and returns it as a byte to the UART transmit path through a valid/busy handshake.

Parameters:
DATA_WIDTH, 8, width of the command/data bytes and the register data
ADDR_WIDTH, 4, register file address width; taken from the low ADDR_WIDTH bits of the address byte
WR_CMD, 8'hAA, opcode for a write frame: {WR_CMD, addr, data}
RD_CMD, 8'hBB, opcode for a read frame: {RD_CMD, addr}
TIMEOUT_CYCLES, 16, read-response timeout in clocks; used only with the optional feature

Ports:
i_CLK  in  1  system clock, rising edge
i_RST  in  1  asynchronous, active-low reset
i_RX_Data  in  DATA_WIDTH  received byte
i_RX_Valid  in  1  one-cycle strobe; i_RX_Data is valid this cycle
o_RF_WrEn  out  1  register file write strobe
o_RF_RdEn  out  1  register file read strobe
o_RF_Address  out  ADDR_WIDTH  register file address
o_RF_WrData  out  DATA_WIDTH  register file write data
i_RF_RdData  in  DATA_WIDTH  register file read data
i_RF_RdData_Valid  in  1  read data valid strobe
o_TX_Data  out  DATA_WIDTH  byte to transmit
o_TX_Valid  out  1  o_TX_Data is valid
i_TX_Busy  in  1  transmitter cannot accept a byte
o_Busy  out  1  high in any state other than IDLE, WR_ADDR, WR_DATA and RD_ADDR
o_Err  out  1  read timeout flag; present only with the optional feature

Behaviour:
- Reset: i_RST low asynchronously forces the state to IDLE. All outputs and internal registers go to 0. Reset mid-frame discards the partial frame, and no strobe is issued afterwards.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE, on i_RX_Valid:
  - byte == WR_CMD -> WR_ADDR
  - byte == RD_CMD -> RD_ADDR
  - any other byte -> ignored; stay in IDLE with no outputs.
- WR_ADDR, on i_RX_Valid: latch i_RX_Data[ADDR_WIDTH-1:0] into o_RF_Address -> WR_DATA.
- WR_DATA, on i_RX_Valid: latch byte into o_RF_WrData -> WR_EXEC.
- WR_EXEC: o_RF_WrEn = 1 for exactly one cycle, with address and data stable -> IDLE. o_RF_WrEn is registered, so it rises on the clock edge after the data byte is accepted.
- RD_ADDR, on i_RX_Valid: latch the address -> RD_EXEC.
- RD_EXEC: o_RF_RdEn = 1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: when i_RF_RdData_Valid = 1, capture i_RF_RdData into o_TX_Data -> TX_SEND.
  - Valid arriving in the same cycle as the RdEn pulse is not accepted; only RD_WAIT samples it.
  - Without the optional feature, RD_WAIT waits indefinitely.
- TX_SEND:
  - o_TX_Valid = 1, with o_TX_Data held stable.
  - A transfer completes on any cycle where o_TX_Valid = 1 and i_TX_Busy = 0.
  - The next cycle o_TX_Valid = 0 and the state goes to IDLE.
  - While i_TX_Busy = 1, o_TX_Valid and the data stay held.
- i_RX_Valid in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: the byte is dropped; there is no buffering.
- Strobes (o_RF_WrEn, o_RF_RdEn) are never asserted together and never longer than one cycle.
- o_RF_Address and o_RF_WrData hold their last values between frames; o_TX_Data holds its last value after transfer.

Optional Feature:
Macro RF_CMD_CTRL_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_WAIT.
  - If TIMEOUT_CYCLES clocks elapse without i_RF_RdData_Valid, o_TX_Data is loaded with all ones (8'hFF) and the state goes to TX_SEND.
  - o_Err is set sticky; it clears only on reset or on the next accepted WR_CMD/RD_CMD opcode byte.
  - The counter clears on entry to RD_WAIT.
- Not defined: no counter and no o_Err port; RD_WAIT waits indefinitely.

Test Plan:
- Write frame: RX bytes 8'hAA, 8'h07, 8'h64 -> exactly one o_RF_WrEn pulse, with o_RF_Address = 7 and o_RF_WrData = 100, on the cycle after the third byte; o_TX_Valid stays 0.
- Read frame: RX 8'hBB, 8'h0A; the register file model returns 8'hC8 with RdData_Valid one cycle after RdEn -> one o_RF_RdEn pulse at address 10, then o_TX_Valid with o_TX_Data = 8'hC8.
- TX backpressure: the read frame above with i_TX_Busy held high for 5 cycles -> o_TX_Valid and o_TX_Data = 8'hC8 held stable for 5 cycles; single transfer when Busy drops; back to IDLE with o_Busy = 0.
- Bad opcode and dropped bytes: RX 8'h55 in IDLE -> no strobes. RX 8'h11 during RD_WAIT -> ignored, and the read result is still returned correctly.
- Reset mid-frame: RX 8'hAA, 8'h03, then i_RST low for one cycle, then RX 8'h99 -> no o_RF_WrEn ever; all outputs 0; the next frame 8'hAA, 8'h03, 8'h22 writes normally.
- With RF_CMD_CTRL_TIMEOUT_EN: read frame, register file never returns valid -> after 16 cycles in RD_WAIT, o_TX_Data = 8'hFF, o_TX_Valid = 1 and o_Err = 1; the next opcode 8'hAA clears o_Err.
